// File: rtl/eprisc_bus_bridge.sv
// Memory-side bus bridge: one word access at a time from the epRISC core to the board ROM/RAM.
// Decodes the region, sequences CE/OE/WE with per-region wait states, owns the shared data bus
// only while writing, and returns a single-cycle acknowledge.
module eprisc_bus_bridge #(
  parameter int unsigned pWaitROM = 2,
  parameter int unsigned pWaitRAM = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oAck,
  output logic        oFault,
  output logic [7:0]  oMemAddr,
  inout  wire  [31:0] bMemData,
  output logic        oRomCE,
  output logic        oRamCE,
  output logic        oMemOE,
  output logic        oMemWE
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StCapture,
    StAck,
    StTurn
  } state_e;

  // Counter is loaded with wait-1 so that zero marks the final STROBE cycle.
  localparam logic [3:0] WaitRom = 4'(pWaitROM - 1);
  localparam logic [3:0] WaitRam = 4'(pWaitRAM - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        write_q, write_d;
  logic        ram_q, ram_d;
  logic        fault_q, fault_d;

  logic hit_rom, hit_ram, fault_dec;
  logic in_access;

  assign hit_rom   = (iAddr[31:8] == 24'h000000);
  assign hit_ram   = (iAddr[31:8] == 24'h000001);
  assign fault_dec = !(hit_rom || hit_ram) || (hit_rom && iWrite);

  // State and datapath registers; synchronous reset returns everything to idle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      ram_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      ram_q   <= ram_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: accept/decode in idle, count wait states, capture read data on the last strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    ram_d   = ram_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (iReq) begin
          if (fault_dec) begin
            state_d = StAck;
            fault_d = 1'b1;
            if (!iWrite) rdata_d = '0;
          end else begin
            state_d = StSetup;
            fault_d = 1'b0;
            addr_d  = iAddr[7:0];
            wdata_d = iWData;
            write_d = iWrite;
            ram_d   = hit_ram;
          end
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = ram_q ? WaitRam : WaitRom;
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
          if (!write_q) rdata_d = bMemData;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: state_d = StAck;
      StAck:     state_d = StTurn;
      // iReq is deliberately not looked at here; the core gets one cycle to drop it.
      StTurn:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are decoded from state so reset clears them on the very next cycle.
  assign in_access = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StCapture);

  assign oRomCE   = in_access && !ram_q;
  assign oRamCE   = in_access && ram_q;
  assign oMemOE   = (state_q == StStrobe) && !write_q;
  assign oMemWE   = (state_q == StStrobe) && write_q;
  assign oAck     = (state_q == StAck);
  assign oFault   = (state_q == StAck) && fault_q;
  assign oRData   = rdata_q;
  assign oMemAddr = addr_q;
  assign bMemData = (in_access && write_q) ? wdata_q : 32'hzzzz_zzzz;

endmodule
